memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ram_start_addr, default 32'h00020000, lowest RAM address; addresses below it are memory-mapped IO (MMIO).
REQ-002 SHALL have parameter mmio_timeout, default 255, max cycles spent waiting for MMIO write completion.
REQ-003 SHALL have port clock  input  1  single clock; all state on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req_valid  input  1  fetch-port read request.
REQ-006 SHALL have port if_req_addr  input  XLEN  fetch read address.
REQ-007 SHALL have port if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_resp_valid  output  1  fetch read data valid, one-cycle pulse.
REQ-009 SHALL have port if_resp_data  output  XLEN  fetch read data.
REQ-010 SHALL have port d_req_valid  input  1  data-port request.
REQ-011 SHALL have port d_req  input  mem_write_control_t  data request: addr, value, width, enable (1 = write).
REQ-012 SHALL have port d_req_ready  output  1  data request accepted this cycle.
REQ-013 SHALL have port d_resp_valid  output  1  data completion pulse; read data or write ack.
REQ-014 SHALL have port d_resp_data  output  XLEN  read data; 0 for writes.
REQ-015 SHALL have port d_resp_error  output  1  with d_resp_valid: MMIO write timed out.
REQ-016 SHALL have port mem_addr  output  XLEN  shared memory address.
REQ-017 SHALL have port mem_w_enable  output  1  shared memory write strobe.
REQ-018 SHALL have port mem_w_data  output  XLEN  shared memory write data.
REQ-019 SHALL have port mem_w_width  output  write_width_t  write width.
REQ-020 SHALL have port mem_r_data  input  XLEN  memory read data, valid one cycle after address.
REQ-021 SHALL have port mmio_write_complete  input  1  MMIO device finished the current write.

Function
REQ-022 SHALL implement FSM states IDLE, READ_WAIT, MMIO_WAIT.
REQ-023 In IDLE, SHALL assert exactly one of if_req_ready/d_req_ready, toward a valid requester; neither when no request is valid; both ready outputs SHALL be 0 outside IDLE.
REQ-024 When both requests are valid, SHALL grant the port not granted most recently (round-robin pointer, updated on each accept).
REQ-025 On accept (valid && ready), SHALL drive mem_addr, mem_w_data, mem_w_width and mem_w_enable from the winner in that same cycle.
REQ-026 On a read, SHALL go to READ_WAIT and, the next cycle, pulse the winner's resp_valid with resp_data = mem_r_data, then return to IDLE.
REQ-027 On a RAM write (addr >= ram_start_addr), SHALL pulse mem_w_enable for one cycle, go to READ_WAIT, and pulse d_resp_valid next cycle with d_resp_data 0.
REQ-028 On an MMIO write (addr < ram_start_addr), SHALL go to MMIO_WAIT with mem_* outputs and mem_w_enable held stable until mmio_write_complete is sampled high.
REQ-029 In MMIO_WAIT, SHALL pulse d_resp_valid on the cycle after completion is sampled, then return to IDLE.
REQ-030 An 8-bit wait counter SHALL increment each MMIO_WAIT cycle; when it reaches mmio_timeout, SHALL drop mem_w_enable, pulse d_resp_valid with d_resp_error = 1, and return to IDLE.
REQ-031 mmio_write_complete outside MMIO_WAIT SHALL be ignored.
REQ-032 Fetch-port requests to MMIO addresses SHALL be treated as reads; fetch writes do not exist.
REQ-033 Request inputs SHALL be sampled only at accept; requesters may change them afterwards.
REQ-034 Throughput SHALL be one transaction per 2 cycles for RAM (accept + response), back-to-back.

Reset
REQ-035 On reset_n low, SHALL asynchronously enter IDLE, clear the wait counter, and point round-robin to favour the data port first.
REQ-036 During reset, all ready, resp_valid, resp_error and mem_w_enable outputs SHALL be 0, and resp_data SHALL be 0.
REQ-037 Reset mid-transaction SHALL drop the transaction; no response pulse follows.

Structure
REQ-038 arbiter_state_t and the round-robin port enum SHALL be in the shared package alongside mem_write_control_t, write_width_t and XLEN.
REQ-039 The grant decision SHALL be a sub-module rr_arbiter2 (two requests, pointer, one-hot grant).

Verification
REQ-040 Fetch-only read of 0x00020010 holding 0xDEADBEEF -> if_req_ready at cycle 0, if_resp_valid at cycle 1 with 0xDEADBEEF.
REQ-041 Both ports valid for 4 accepts from reset -> grant order data, fetch, data, fetch.
REQ-042 Data write of 0x12345678 (word) to 0x00000004 with completion at wait cycle 5 -> mem_w_enable is held 6 cycles, then d_resp_valid=1 with d_resp_error=0; fetch is stalled throughout.
REQ-043 MMIO write with completion never asserted -> d_resp_error=1 after 255 wait cycles, and the arbiter returns to IDLE.
REQ-044 reset_n low in MMIO_WAIT -> immediate IDLE, all outputs 0, and no d_resp_valid after release.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared widths, request types and state encodings for the memory arbiter
package memory_arbiter_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD} write_width_t;
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        write_width_t    width;
        logic            enable;
    } mem_write_control_t;
    typedef enum logic [1:0] {IDLE, READ_WAIT, MMIO_WAIT} arbiter_state_t;
    typedef enum logic {PORT_DATA, PORT_FETCH} rr_port_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch port, data port and shared memory bus of the memory arbiter
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;
    logic               if_req_valid;
    logic [XLEN-1:0]    if_req_addr;
    logic               if_req_ready;
    logic               if_resp_valid;
    logic [XLEN-1:0]    if_resp_data;
    logic               d_req_valid;
    mem_write_control_t d_req;
    logic               d_req_ready;
    logic               d_resp_valid;
    logic [XLEN-1:0]    d_resp_data;
    logic               d_resp_error;
    logic [XLEN-1:0]    mem_addr;
    logic               mem_w_enable;
    logic [XLEN-1:0]    mem_w_data;
    write_width_t       mem_w_width;
    logic [XLEN-1:0]    mem_r_data;
    logic               mmio_write_complete;
    modport slave (
        input  if_req_valid, if_req_addr, d_req_valid, d_req, mem_r_data, mmio_write_complete,
        output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
               d_resp_data, d_resp_error, mem_addr, mem_w_enable, mem_w_data, mem_w_width
    );
    modport master (
        output if_req_valid, if_req_addr, d_req_valid, d_req, mem_r_data, mmio_write_complete,
        input  if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid,
               d_resp_data, d_resp_error, mem_addr, mem_w_enable, mem_w_data, mem_w_width
    );
endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way one-hot grant; the favoured port wins a tie, a lone requester always wins
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  rr_port_t   prio,
    output logic [1:0] gnt
);
    // bit 0 is the data port, bit 1 the fetch port
    always_comb begin
        gnt[0] = req[0] && (prio == PORT_DATA || !req[1]);
        gnt[1] = req[1] && (prio == PORT_FETCH || !req[0]);
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one memory bus between a fetch port and a data port
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter logic [XLEN-1:0] ram_start_addr = 32'h00020000,
    parameter int              mmio_timeout   = 255
) (
    input logic             clock,
    input logic             reset_n,
    memory_arbiter_if.slave bus
);
    arbiter_state_t     state_q, state_d;
    rr_port_t           last_q, last_d;
    rr_port_t           port_q, port_d;
    logic [7:0]         wait_q, wait_d;
    mem_write_control_t req_q, req_d;
    mem_write_control_t fetch_ctl, win;
    logic [1:0]         gnt;
    logic               idle, accept, timeout, resp;

    assign idle      = state_q == IDLE && reset_n;
    assign accept    = |gnt;
    assign timeout   = state_q == MMIO_WAIT && wait_q == 8'(mmio_timeout);
    assign resp      = state_q == READ_WAIT;
    assign fetch_ctl = '{addr: bus.if_req_addr, value: '0, width: WIDTH_WORD, enable: 1'b0};
    assign win       = gnt[0] ? bus.d_req : fetch_ctl;

    rr_arbiter2 u_rr (
        .req  ({bus.if_req_valid, bus.d_req_valid} & {2{idle}}),
        .prio (last_q == PORT_DATA ? PORT_FETCH : PORT_DATA),
        .gnt  (gnt)
    );

    // state, last-served port, responding port, wait counter and the captured request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= PORT_FETCH;
            port_q  <= PORT_DATA;
            wait_q  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
        end
    end

    // capture the winner on accept; writes below RAM wait for the device or the timeout
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        wait_d  = wait_q;
        req_d   = req_q;
        if (accept) begin
            last_d  = gnt[0] ? PORT_DATA : PORT_FETCH;
            port_d  = gnt[0] ? PORT_DATA : PORT_FETCH;
            req_d   = win;
            wait_d  = '0;
            state_d = win.enable && win.addr < ram_start_addr ? MMIO_WAIT : READ_WAIT;
        end else if (state_q == READ_WAIT) begin
            state_d = IDLE;
        end else if (state_q == MMIO_WAIT) begin
            wait_d  = wait_q + 8'd1;
            state_d = timeout ? IDLE : bus.mmio_write_complete ? READ_WAIT : MMIO_WAIT;
        end
    end

    // handshakes, response pulses and the shared bus (winner directly on accept, held copy after)
    always_comb begin
        bus.if_req_ready  = gnt[1];
        bus.d_req_ready   = gnt[0];
        bus.if_resp_valid = resp && port_q == PORT_FETCH;
        bus.if_resp_data  = resp && port_q == PORT_FETCH ? bus.mem_r_data : '0;
        bus.d_resp_valid  = (resp && port_q == PORT_DATA) || timeout;
        bus.d_resp_data   = resp && port_q == PORT_DATA && !req_q.enable ? bus.mem_r_data : '0;
        bus.d_resp_error  = timeout;
        bus.mem_addr      = accept ? win.addr : req_q.addr;
        bus.mem_w_data    = accept ? win.value : req_q.value;
        bus.mem_w_width   = accept ? win.width : req_q.width;
        bus.mem_w_enable  = accept ? win.enable : state_q == MMIO_WAIT && !timeout;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and random transactions checked against a transaction-level model
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam logic [XLEN-1:0] RAM_START = 32'h00020000;

    logic clock = 1'b0;
    logic reset_n;
    int n_cmp = 0;
    int n_err = 0;
    logic last_fetch;
    logic r_fv, r_dv;
    mem_write_control_t dc;

    memory_arbiter_if bus();

    memory_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] rd(input logic [XLEN-1:0] a);
        return a == 32'h00020010 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // memory returns the word for the address presented one cycle earlier
    always @(posedge clock) bus.mem_r_data <= rd(bus.mem_addr);

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'({bus.if_req_ready, bus.d_req_ready}), 32'd0);
        check({tag, "_resp_valid"}, 32'({bus.if_resp_valid, bus.d_resp_valid}), 32'd0);
        check({tag, "_resp_error"}, 32'(bus.d_resp_error), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_w_enable), 32'd0);
        check({tag, "_if_data"}, bus.if_resp_data, 32'd0);
        check({tag, "_d_data"}, bus.d_resp_data, 32'd0);
    endtask

    task automatic scramble();
        bus.if_req_addr   = $urandom;
        bus.d_req.addr    = $urandom;
        bus.d_req.value   = $urandom;
        bus.d_req.enable  = 1'($urandom_range(0, 1));
    endtask

    // one complete transaction: accept cycle, optional MMIO wait cycles (cdel 0 = never completes), response cycle
    task automatic run_txn(input logic fv, input logic [XLEN-1:0] fa, input logic dv,
                           input mem_write_control_t c, input int cdel);
        logic win_d, mmio, wr;
        logic [XLEN-1:0] a;
        win_d = dv && (!fv || last_fetch);
        wr    = win_d && c.enable;
        a     = win_d ? c.addr : fa;
        mmio  = wr && c.addr < RAM_START;
        @(negedge clock);
        bus.if_req_valid = fv;
        bus.if_req_addr  = fa;
        bus.d_req_valid  = dv;
        bus.d_req        = c;
        bus.mmio_write_complete = 1'($urandom_range(0, 1));
        #1;
        check("if_req_ready", 32'(bus.if_req_ready), 32'(fv && !win_d));
        check("d_req_ready", 32'(bus.d_req_ready), 32'(win_d));
        check("mem_addr", bus.mem_addr, a);
        check("mem_w_enable", 32'(bus.mem_w_enable), 32'(wr));
        if (wr) begin
            check("mem_w_data", bus.mem_w_data, c.value);
            check("mem_w_width", 32'(bus.mem_w_width), 32'(c.width));
        end
        last_fetch = !win_d;
        for (int k = 1; mmio && k <= (cdel != 0 ? cdel : 255); k++) begin
            @(negedge clock);
            scramble();
            bus.mmio_write_complete = k == cdel;
            #1;
            check("mmio_we_hold", 32'(bus.mem_w_enable), 32'd1);
            check("mmio_addr_hold", bus.mem_addr, a);
            check("mmio_data_hold", bus.mem_w_data, c.value);
            check("mmio_stall", 32'({bus.if_req_ready, bus.d_req_ready, bus.d_resp_valid}), 32'd0);
        end
        @(negedge clock);
        scramble();
        bus.mmio_write_complete = mmio ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        check("d_resp_valid", 32'(bus.d_resp_valid), 32'(win_d));
        check("if_resp_valid", 32'(bus.if_resp_valid), 32'(!win_d));
        check("d_resp_error", 32'(bus.d_resp_error), 32'(mmio && cdel == 0));
        if (win_d) check("d_resp_data", bus.d_resp_data, wr ? 32'd0 : rd(a));
        else check("if_resp_data", bus.if_resp_data, rd(a));
        check("resp_we", 32'(bus.mem_w_enable), 32'd0);
        check("resp_ready", 32'({bus.if_req_ready, bus.d_req_ready}), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.d_req_valid  = 1'b1;
        bus.if_req_addr  = RAM_START;
        bus.d_req        = '0;
        bus.mmio_write_complete = 1'b0;
        last_fetch = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_quiet("reset");
        @(negedge clock);
        reset_n = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;

        dc = '0;
        run_txn(1'b1, 32'h00020010, 1'b0, dc, 1);
        dc.addr = 32'h00020100;
        repeat (4) run_txn(1'b1, 32'h00020200, 1'b1, dc, 1);

        dc.addr = 32'h00000004; dc.value = 32'h12345678; dc.width = WIDTH_WORD; dc.enable = 1'b1;
        run_txn(1'b1, 32'h00020020, 1'b1, dc, 5);

        dc.addr = 32'h00000100; dc.value = 32'hCAFEF00D; dc.width = WIDTH_HALF;
        run_txn(1'b0, 32'h0, 1'b1, dc, 0);

        dc.addr = 32'h00020040; dc.value = 32'h0BADF00D; dc.width = WIDTH_BYTE;
        run_txn(1'b0, 32'h0, 1'b1, dc, 1);
        run_txn(1'b1, 32'h00000080, 1'b0, dc, 1);

        @(negedge clock);
        dc.addr = 32'h00000008; dc.value = 32'h55AA55AA; dc.width = WIDTH_WORD; dc.enable = 1'b1;
        bus.d_req = dc;
        bus.d_req_valid  = 1'b1;
        bus.if_req_valid = 1'b0;
        #1;
        check("rst_accept", 32'(bus.d_req_ready), 32'd1);
        @(negedge clock);
        bus.d_req_valid = 1'b0;
        @(negedge clock);
        bus.if_req_valid = 1'b1;
        bus.d_req_valid  = 1'b1;
        reset_n = 1'b0;
        #1;
        check_quiet("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        bus.mmio_write_complete = 1'b1;
        last_fetch = 1'b1;
        repeat (4) begin
            @(negedge clock);
            #1;
            check("post_reset_quiet", 32'({bus.d_resp_valid, bus.if_resp_valid, bus.mem_w_enable}), 32'd0);
        end
        bus.mmio_write_complete = 1'b0;
        dc.enable = 1'b0;
        dc.addr = 32'h00020300;
        run_txn(1'b1, 32'h00020400, 1'b1, dc, 1);

        for (int i = 0; i < 80; i++) begin
            r_fv = 1'($urandom_range(0, 1));
            r_dv = 1'($urandom_range(0, 1));
            if (!r_fv && !r_dv) r_fv = 1'b1;
            dc.enable = 1'($urandom_range(0, 1));
            dc.addr = $urandom_range(0, 1) ? RAM_START + (32'($urandom_range(0, 4095)) << 2)
                                           : 32'($urandom_range(0, 32'h7FFF)) << 2;
            dc.value = $urandom;
            dc.width = write_width_t'($urandom_range(0, 2));
            run_txn(r_fv, $urandom, r_dv, dc, $urandom_range(1, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
